// File: rtl/disp_write_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | disp_write_sched: round-robin write scheduler for the 8-digit display.    |
// | Optional burst writes via SCHED_BURST_EN.  Rev 1.0                        |
// +--------------------------------------------------------------------------+
module disp_write_sched #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_burst,
  input  logic [3*NUM_REQ-1:0]    req_sel,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      ack,
  output logic                    done,
  output logic                    busy,
  output logic [2:0]              grant_id,
  output logic                    write,
  output logic [2:0]              sel,
  output logic [3:0]              num
);

  localparam int             HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [3:0]     NR        = 4'(NUM_REQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
`ifdef SCHED_BURST_EN
  localparam logic [1:0] GAP  = 2'd2;
`endif
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [2:0]    rr_ptr;
  logic [HW-1:0] hold_cnt;

  logic [7:0]    req_pad;
  logic          arb_valid;
  logic [2:0]    arb_idx;
  logic [3:0]    cand;
  logic [2:0]    rr_next;
  logic [2:0]    pick_sel;

`ifdef SCHED_BURST_EN
  logic          pick_burst;
  logic [31:0]   pick_data;
  logic          lat_burst;
  logic [31:0]   lat_data;
  logic [2:0]    digit;
  logic [2:0]    digit_nx;
  assign digit_nx = digit + 3'd1;
`else
  logic [3:0]    pick_nib;
  logic          unused_bits;
  assign unused_bits = ^{req_burst, req_data};
`endif

  assign req_pad = 8'(req);
  assign busy    = (state != IDLE);
  assign rr_next = (arb_idx == 3'(NUM_REQ - 1)) ? 3'd0 : arb_idx + 3'd1;

  // First asserted request at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = 3'd0;
    cand      = 4'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + 4'(k);
      if (cand >= NR) cand = cand - NR;
      if (!arb_valid && req_pad[cand[2:0]]) begin
        arb_valid = 1'b1;
        arb_idx   = cand[2:0];
      end
    end
  end

  always_comb begin
    pick_sel = 3'd0;
`ifdef SCHED_BURST_EN
    pick_burst = 1'b0;
    pick_data  = 32'd0;
`else
    pick_nib   = 4'd0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == 3'(i)) begin
        pick_sel = req_sel[3*i +: 3];
`ifdef SCHED_BURST_EN
        pick_burst = req_burst[i];
        pick_data  = req_data[32*i +: 32];
`else
        pick_nib   = req_data[32*i +: 4];
`endif
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i] = (state == IDLE) && arb_valid && (arb_idx == 3'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= 3'd0;
      grant_id <= 3'd0;
      hold_cnt <= '0;
      write    <= 1'b0;
      sel      <= 3'd0;
      num      <= 4'd0;
      done     <= 1'b0;
`ifdef SCHED_BURST_EN
      lat_burst <= 1'b0;
      lat_data  <= 32'd0;
      digit     <= 3'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant_id <= arb_idx;
            rr_ptr   <= rr_next;
            hold_cnt <= '0;
            write    <= 1'b1;
`ifdef SCHED_BURST_EN
            // Burst digit 0 and a single write both take the low nibble.
            lat_burst <= pick_burst;
            lat_data  <= pick_data;
            digit     <= pick_burst ? 3'd0 : pick_sel;
            sel       <= pick_burst ? 3'd0 : pick_sel;
            num       <= pick_data[3:0];
`else
            sel       <= pick_sel;
            num       <= pick_nib;
`endif
            state    <= WR;
          end
        end
        WR: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            write    <= 1'b0;
`ifdef SCHED_BURST_EN
            if (lat_burst && (digit != 3'd7)) begin
              state <= GAP;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
`else
            state <= DONE;
            done  <= 1'b1;
`endif
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
`ifdef SCHED_BURST_EN
        GAP: begin
          digit <= digit_nx;
          sel   <= digit_nx;
          num   <= lat_data[{digit_nx, 2'b00} +: 4];
          write <= 1'b1;
          state <= WR;
        end
`endif
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_disp_write_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_disp_write_sched: self-checking bench with a schedule-queue model.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_disp_write_sched;

  localparam int NUM_REQ = 4;
  localparam int HOLD    = 2;
`ifdef SCHED_BURST_EN
  localparam int BURST_ON = 1;
`else
  localparam int BURST_ON = 0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ-1:0]    req_burst = '0;
  logic [3*NUM_REQ-1:0]  req_sel = '0;
  logic [32*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]    ack;
  logic                  done, busy, write;
  logic [2:0]            grant_id, sel;
  logic [3:0]            num;

  disp_write_sched #(.NUM_REQ(NUM_REQ), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .req(req), .req_burst(req_burst),
    .req_sel(req_sel), .req_data(req_data), .ack(ack), .done(done),
    .busy(busy), .grant_id(grant_id), .write(write), .sel(sel), .num(num)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  bit en         = 1'b0;

  task automatic chk(string nm, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: each grant expands into the exact per-cycle output schedule.
  typedef struct packed {
    logic       wr;
    logic [2:0] sl;
    logic [3:0] nb;
    logic       dn;
  } ent_t;

  ent_t q[$];
  int   m_rr = 0, m_grant = 0;
  logic [2:0] last_sel = '0;
  logic [3:0] last_num = '0;
  ent_t e;
  int   win;
  logic [NUM_REQ-1:0] e_ack;
  logic [31:0] wd;
  logic [2:0]  ws;

  int ack_idx[$], ack_cyc[$], done_cyc[$], done_wr[$];
  int wr_run = 0;

  always @(negedge clk) begin
    if (en) begin
      cyc++;
      if (q.size() > 0) e = q[0];
      else e = '{wr: 1'b0, sl: last_sel, nb: last_num, dn: 1'b0};
      win   = -1;
      e_ack = '0;
      if (q.size() == 0) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (win < 0 && req[(m_rr + k) % NUM_REQ]) win = (m_rr + k) % NUM_REQ;
        end
        if (win >= 0) e_ack[win] = 1'b1;
      end
      chk("write", int'(write), int'(e.wr));
      chk("sel", int'(sel), int'(e.sl));
      chk("num", int'(num), int'(e.nb));
      chk("done", int'(done), int'(e.dn));
      chk("busy", int'(busy), (q.size() > 0) ? 1 : 0);
      chk("grant_id", int'(grant_id), m_grant);
      chk("ack", int'(ack), int'(e_ack));

      if (write) wr_run++;
      if (ack != '0) begin
        for (int i = 0; i < NUM_REQ; i++) if (ack[i]) ack_idx.push_back(i);
        ack_cyc.push_back(cyc);
        wr_run = 0;
      end
      if (done) begin
        done_cyc.push_back(cyc);
        done_wr.push_back(wr_run);
      end

      if (reset) begin
        q.delete();
        m_rr = 0; m_grant = 0; last_sel = '0; last_num = '0;
      end else if (q.size() > 0) begin
        last_sel = q[0].sl;
        last_num = q[0].nb;
        void'(q.pop_front());
      end else if (win >= 0) begin
        wd = req_data[32*win +: 32];
        ws = req_sel[3*win +: 3];
        if (BURST_ON == 1 && req_burst[win]) begin
          for (int d = 0; d < 8; d++) begin
            repeat (HOLD) q.push_back('{wr: 1'b1, sl: 3'(d), nb: wd[4*d +: 4], dn: 1'b0});
            if (d < 7) q.push_back('{wr: 1'b0, sl: 3'(d), nb: wd[4*d +: 4], dn: 1'b0});
          end
          q.push_back('{wr: 1'b0, sl: 3'd7, nb: wd[31:28], dn: 1'b1});
        end else begin
          repeat (HOLD) q.push_back('{wr: 1'b1, sl: ws, nb: wd[3:0], dn: 1'b0});
          q.push_back('{wr: 1'b0, sl: ws, nb: wd[3:0], dn: 1'b1});
        end
        m_grant = win;
        m_rr    = (win + 1) % NUM_REQ;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [2:0] s, logic [31:0] d, logic b);
    req_sel[3*i +: 3]   = s;
    req_data[32*i +: 32] = d;
    req_burst[i]        = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle(int budget, string nm);
    int t = 0;
    while ((busy || q.size() > 0) && t < budget) begin
      tick();
      t++;
    end
    chk(nm, int'(busy), 0);
  endtask

  task automatic wait_acks(int n, int budget, string nm);
    int t = 0;
    while (ack_idx.size() < n && t < budget) begin
      tick();
      t++;
    end
    chk(nm, (ack_idx.size() >= n) ? 1 : 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int base, d0;

  initial begin
    tick();
    tick();
    en    = 1'b1;
    reset = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_write", int'(write), 0);
    chk("rst_grant", int'(grant_id), 0);

    // Single write from requester 0.
    set_req(0, 3'd5, 32'h0000000A, 1'b0);
    req = 4'b0001;
    tick();
    req = '0;
    chk("t1_write", int'(write), 1);
    chk("t1_sel", int'(sel), 5);
    chk("t1_num", int'(num), 10);
    tick();
    tick();
    chk("t1_done", int'(done), 1);
    tick();
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_latency", done_cyc[$] - ack_cyc[$], HOLD + 1);

    // Burst from requester 2.
    set_req(2, 3'd6, 32'h76543210, 1'b1);
    d0  = done_cyc.size();
    req = 4'b0100;
    tick();
    req = '0;
    wait_idle(40, "t2_idle");
    chk("t2_done_count", done_cyc.size() - d0, 1);
    chk("t2_latency", done_cyc[$] - ack_cyc[$], (BURST_ON == 1) ? 24 : 3);
    chk("t2_write_cycles", done_wr[$], (BURST_ON == 1) ? 16 : 2);
    chk("t2_grant", int'(grant_id), 2);

    // All requesters held: rotation from 0 after reset.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'(i), 32'(i + 1), 1'b0);
    base = ack_idx.size();
    req  = 4'b1111;
    wait_acks(base + 5, 60, "t3_acks");
    req = '0;
    wait_idle(20, "t3_idle");
    for (int i = 0; i < 5; i++) chk($sformatf("t3_rr_order%0d", i), ack_idx[base + i], i % 4);

    // Requester 1 arrives during requester 0's burst.
    do_reset();
    set_req(0, 3'd0, 32'h13579BDF, 1'b1);
    set_req(1, 3'd2, 32'h00000004, 1'b0);
    req = 4'b0001;
    tick();
    req  = 4'b0010;
    base = ack_idx.size();
    wait_acks(base + 1, 60, "t4_ack1");
    req = '0;
    chk("t4_grant1", ack_idx[$], 1);
    chk("t4_after_done", ack_cyc[$] - done_cyc[$], 1);
    wait_idle(20, "t4_idle");

    // Reset during the 4th digit of a burst.
    do_reset();
    set_req(0, 3'd1, 32'hFEDCBA98, 1'b1);
    d0  = done_cyc.size();
    req = 4'b0001;
    tick();
    req = '0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("t5_busy", int'(busy), 0);
    chk("t5_write", int'(write), 0);
    chk("t5_no_done", done_cyc.size() - d0, (BURST_ON == 1) ? 0 : 1);
    set_req(1, 3'd1, 32'h00000005, 1'b0);
    set_req(2, 3'd2, 32'h00000006, 1'b0);
    req = 4'b0110;
    tick();
    req = '0;
    chk("t5_lowest", ack_idx[$], 1);
    wait_idle(20, "t5_idle");

    // Burst flag on requester 3: single write when bursts are compiled out.
    set_req(3, 3'd3, 32'h12345679, 1'b1);
    req = 4'b1000;
    tick();
    req = '0;
    chk("t6_sel", int'(sel), (BURST_ON == 1) ? 0 : 3);
    chk("t6_num", int'(num), 9);
    wait_idle(40, "t6_idle");
    chk("t6_latency", done_cyc[$] - ack_cyc[$], (BURST_ON == 1) ? 24 : 3);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/disp_write_sched.md
Name: disp_write_sched

Overview:
- Round-robin write scheduler for the 8-digit seven-segment display block.
- Arbitrates between NUM_REQ requesters (switch panel, counters, debug sources) that want to update display digits.
- Drives the display's write/sel/num inputs. Between write operations, write is held low so the display's own scan runs undisturbed.
- Supports single-digit writes, and burst writes of all 8 digits from a 32-bit word.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 2, clk cycles write is held high per digit (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level. Must be held until acked.
- req_burst  in  NUM_REQ  1 = burst write of all 8 digits; 0 = single digit.
- req_sel  in  3*NUM_REQ  digit index for single writes. Requester i uses bits [3i+2:3i].
- req_data  in  32*NUM_REQ  requester i uses bits [32i+31:32i].
  - Single write: nibble = bits [3:0] of the slice.
  - Burst write: digit k takes bits [4k+3:4k] of the slice.
- ack  out  NUM_REQ  one-cycle accept pulse. Request contents are latched on this cycle.
- done  out  1  one-cycle pulse when the granted operation finishes.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  3  index of the current or last granted requester.
- write  out  1  to display write input.
- sel  out  3  to display sel input.
- num  out  4  to display num input.

Behaviour:
- Reset values: state IDLE; write=0, sel=0, num=0, ack=0, done=0, busy=0, grant_id=0, rr_ptr=0.
- States: IDLE, WR, GAP, DONE.
- IDLE, arbitration:
  - Search req starting at rr_ptr, wrapping modulo NUM_REQ; the first asserted index i wins.
  - ack[i] is combinational from state==IDLE and the arbitration result: high for exactly that cycle, only one ack bit ever high.
  - On the same edge: latch burst/sel/data of requester i; grant_id<=i; rr_ptr<=(i+1) mod NUM_REQ; digit counter<=0 for burst or req_sel for single; hold counter<=0; go to WR.
  - No req: stay in IDLE.
- WR:
  - write=1, sel=current digit, num=current nibble (all registered outputs, stable for the whole state).
  - Stays for HOLD_CYCLES cycles.
  - Then: if single, or if burst on digit 7, go to DONE. Otherwise go to GAP.
- GAP:
  - One cycle with write=0; sel/num keep their last value.
  - Digit counter increments; go to WR.
- DONE:
  - done=1 for one cycle, write=0; go to IDLE.
- Latency and timing:
  - Request accepted at edge t; write is high for cycles t+1..t+HOLD_CYCLES.
  - Single write: done asserted in cycle t+HOLD_CYCLES+1. Next arbitration possible at t+HOLD_CYCLES+2.
  - Burst write: write high 8*HOLD_CYCLES cycles with 7 GAP cycles; done follows the last WR cycle. Digits are written 0..7 in order.
- Boundary conditions:
  - req still high the cycle after ack is a new request. It competes in the next IDLE cycle.
  - req dropped or changed after ack: no effect; latched contents are used.
  - req asserted while busy: ignored until IDLE; no ack.
  - All requesters asserted continuously: grants rotate 0,1,2,3,0,...
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - req_sel is ignored for bursts. req_burst is ignored when that requester is not granted.
  - reset mid-operation: next edge gives state IDLE with write=0, done and ack low, rr_ptr=0. The interrupted operation is not resumed and done is not pulsed.
  - grant_id upper bits are zero when NUM_REQ<8.

Optional Feature:
- Macro SCHED_BURST_EN.
- Defined: burst writes as above.
- Undefined:
  - req_burst is ignored; every grant is a single-digit write using req_sel and data[3:0].
  - GAP state and burst digit counter logic are not synthesised.
  - Single-write behaviour and timing are identical to the defined case.

Test Plan:
- Reset, then req=0001, req_burst=0, sel0=5, data0=0x0000000A, HOLD_CYCLES=2:
  - ack[0] in the IDLE cycle.
  - write=1, sel=5, num=A for 2 cycles.
  - done next cycle; busy low after.
- Burst from requester 2, data2=0x76543210:
  - 8 WR phases with sel=0..7 and num=0..7, each 2 cycles, separated by 1-cycle write=0 gaps.
  - done once, 24 cycles after ack.
- req=1111 held continuously, all single writes: acks in order 0,1,2,3,0; no requester granted twice before the others.
- Requester 1 raises req during requester 0's burst: no ack[1] until IDLE; requester 1's write starts only after done.
- Assert reset during the 4th digit of a burst:
  - write=0 and busy=0 at the next edge; no done pulse.
  - A following single request is granted to the lowest asserted index (rr_ptr=0).
- Build without SCHED_BURST_EN, req_burst=1, sel=3, data=0x12345679: single write of num=9 to sel=3, done after 2 write cycles.
